// File: rtl/rr_grant4_if.sv
// rr_grant4_if: request/beat handshake and one-hot select bundle for rr_grant4
interface rr_grant4_if;
   logic [3:0] req;
   logic [3:0] req_last;
   logic       out_ready;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       out_valid;
   logic       xfer;
   logic       release_pulse;
   modport master (output req, req_last, out_ready,
                   input grant, grant_idx, out_valid, xfer, release_pulse);
   modport slave (input req, req_last, out_ready,
                  output grant, grant_idx, out_valid, xfer, release_pulse);
endinterface

// File: rtl/rr_grant4.sv
// rr_grant4: four-requester round-robin arbiter driving a one-hot mux select, grant held per transaction
module rr_grant4 #(
   parameter int MAX_BEATS = 16,
   parameter int CW        = 8
) (
   input logic        clk,
   input logic        rst,
   rr_grant4_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state_q, state_d;
   logic [3:0]    grant_q, grant_d;
   logic [1:0]    idx_q, idx_d, ptr_q, ptr_d, sel;
   logic          rel_q, rel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid, xfer, done;
   assign out_valid         = |(grant_q & bus.req);
   assign xfer              = out_valid & bus.out_ready;
   assign bus.grant         = grant_q;
   assign bus.grant_idx     = idx_q;
   assign bus.out_valid     = out_valid;
   assign bus.xfer          = xfer;
   assign bus.release_pulse = rel_q;
   // descending scan so the nearest set bit at or after ptr wins
   always_comb begin
      logic [1:0] j;
      sel = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         j = ptr_q + 2'(k);
         if (bus.req[j]) sel = j;
      end
   end
   assign done = (xfer & bus.req_last[idx_q]) | (xfer & (cnt_q + CW'(1) == CW'(MAX_BEATS))) | !bus.req[idx_q];
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rel_d   = 1'b0;
      if (state_q == IDLE && |bus.req) begin
         state_d = BUSY;
         grant_d = 4'b0001 << sel;
         idx_d   = sel;
         cnt_d   = '0;
      end else if (state_q == BUSY && done) begin
         state_d = IDLE;
         grant_d = '0;
         rel_d   = 1'b1;
         ptr_d   = idx_q + 2'd1;
      end else if (state_q == BUSY && xfer) cnt_d = cnt_q + CW'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
      end
   end
   a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
endmodule

// File: tb/tb_rr_grant4.sv
// tb_rr_grant4: randomized and directed checks of rr_grant4 against a transaction-level model
module tb_rr_grant4;
   localparam int MB = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0, n_fail = 0;
   int   own = -1, last_own = 0, beats = 0, ptr = 0, rel = 0;
   rr_grant4_if bus();
   rr_grant4 #(.MAX_BEATS(MB), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask
   task automatic cycle();
      int  ov, xf, found;
      @(negedge clk);
      ov = (own >= 0) && bus.req[own];
      xf = ov && bus.out_ready;
      if (!rst) begin
         check("grant", 32'(bus.grant), (own < 0) ? 32'd0 : 32'd1 << own);
         check("grant_idx", 32'(bus.grant_idx), 32'(last_own));
         check("out_valid", 32'(bus.out_valid), 32'(ov));
         check("xfer", 32'(bus.xfer), 32'(xf));
         check("release", 32'(bus.release_pulse), 32'(rel));
      end
      if (rst) begin
         own = -1; last_own = 0; beats = 0; ptr = 0; rel = 0;
      end else if (own < 0) begin
         rel = 0;
         found = 0;
         for (int k = 0; k < 4; k++)
            if (!found && bus.req[(ptr + k) % 4]) begin
               found = 1;
               own = (ptr + k) % 4;
            end
         if (found) begin
            last_own = own;
            beats = 0;
         end
      end else if ((xf && bus.req_last[own]) || (xf && beats + 1 == MB) || !bus.req[own]) begin
         rel = 1;
         ptr = (own + 1) % 4;
         own = -1;
      end else begin
         rel = 0;
         if (xf) beats++;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic run(input int n);
      repeat (n) cycle();
   endtask
   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask
   initial begin
      bus.req = '0;
      bus.req_last = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      run(1);
      rst = 1'b0;
      check("reset_grant", 32'(bus.grant), 32'd0);
      check("reset_release", 32'(bus.release_pulse), 32'd0);
      bus.req = 4'b1111; bus.req_last = 4'b1111; bus.out_ready = 1'b1;
      run(11);
      do_reset();
      bus.req = 4'b0010; bus.req_last = 4'b0010;
      run(3);
      bus.req = 4'b0011;
      run(5);
      do_reset();
      bus.req = 4'b0010; bus.req_last = 4'b0000;
      run(8);
      bus.req = 4'b1111;
      run(4);
      do_reset();
      bus.req = 4'b1000; bus.out_ready = 1'b0;
      run(12);
      check("stall_grant", 32'(bus.grant), 32'h8);
      bus.req_last = 4'b1000; bus.out_ready = 1'b1;
      run(3);
      do_reset();
      bus.req = 4'b0001; bus.req_last = 4'b0000;
      run(3);
      bus.req = 4'b0000;
      run(3);
      do_reset();
      bus.req = 4'b0100; bus.out_ready = 1'b0;
      run(3);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      bus.req = 4'b0101;
      run(3);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(63) == 0);
         if ($urandom_range(3) == 0) bus.req = 4'($urandom);
         bus.req_last = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
         bus.out_ready = ($urandom_range(3) != 0);
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_grant4.md
Name: rr_grant4

Overview:
- Four-requester round-robin arbiter that generates the one-hot select for the team's 4-input one-hot mux. The grant output connects directly to the mux select `s`, with requester `i` wired to input `a<i>`.
- Grant is registered and held for a multi-beat transaction. A transaction ends on a last-beat handshake, on an abort (requester drops request), or on a beat-limit timeout.
- The block guarantees the mux select is always either all-zero or exactly one-hot.

Parameters:
- MAX_BEATS, 16: maximum accepted beats per grant before forced release. Legal range 1..255.
- CW, 8: beat counter width. Must satisfy 2^CW > MAX_BEATS.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- req, input, 4: per-requester request; bit i belongs to requester i.
- req_last, input, 4: per-requester last-beat flag; only the bit of the granted requester is sampled.
- out_ready, input, 1: downstream accepts the current beat.
- grant, output, 4: registered one-hot select (4'b0001 = a0 … 4'b1000 = a3); 4'b0000 when idle.
- grant_idx, output, 2: binary index of the current or last granted requester.
- out_valid, output, 1: combinational, equal to |(grant & req).
- xfer, output, 1: combinational, equal to out_valid & out_ready; a beat is accepted this cycle.
- release, output, 1: registered one-cycle pulse in the cycle after grant drops.

Behaviour:
- Reset (rst=1 at clock edge), regardless of state:
  - grant=0, grant_idx=0, release=0, beat_cnt=0, state=IDLE.
  - Round-robin pointer ptr=0, so requester 0 has highest priority first.
  - A mid-transaction reset drops the grant next cycle with no release pulse.
- States:
  - IDLE: grant=0.
  - BUSY: grant is one-hot and constant.
- IDLE -> BUSY:
  - If any req bit is set, select the first set bit scanning ptr, ptr+1, … modulo 4.
  - On the next edge: grant=onehot(sel), grant_idx=sel, beat_cnt=0.
  - Latency from req rise to grant is 1 cycle.
  - req sampled in IDLE is not required to be held; if it has dropped by the BUSY cycle, the abort rule applies.
- In BUSY, each xfer increments beat_cnt.
- BUSY -> IDLE releases, evaluated at the clock edge in this priority order:
  1. Last beat: xfer & req_last[grant_idx].
  2. Timeout: xfer & (beat_cnt+1 == MAX_BEATS).
  3. Abort: req[grant_idx]==0.
- On any release:
  - Next cycle: grant=0, release=1, ptr=grant_idx+1 (mod 4, wrapping 3->0); grant_idx retains its value.
  - Timeout and abort release identically; only the cause differs.
- Mandatory bubble: after a release there is exactly one IDLE cycle before the next grant. Back-to-back grants are therefore 2 cycles apart.
- Backpressure: out_ready=0 in BUSY holds grant and beat_cnt unchanged indefinitely. There is no timeout on stalls.
- Requests from non-granted requesters have no effect while BUSY.
- Invariant, checked by assertion: grant ∈ {0000, 0001, 0010, 0100, 1000} every cycle after reset.
- release is 0 in every cycle other than the single cycle following a release.

Test Plan:
1. Reset, then req=4'b1111 held, req_last=4'b1111, out_ready=1 -> grants 0001, 0010, 0100, 1000, 0001 in turn. Each grant lasts 1 cycle, separated by one idle cycle; release pulses after each.
2. ptr=2 (after requester 1 served), req=4'b0011 -> grant=0001, since requester 2 and 3 are idle and the scan wraps past 3.
3. Grant to requester 1, req_last=0, out_ready=1, MAX_BEATS=4 -> exactly 4 xfer pulses, then grant=0 and release=1. The next arbitration starts from requester 2.
4. Grant to requester 3, out_ready=0 for 10 cycles -> grant stays 4'b1000, xfer=0, beat_cnt=0. Then out_ready=1 with req_last[3]=1 -> one xfer and release.
5. Grant to requester 0, drop req[0] after 2 beats (no last) -> abort: grant=0 next cycle, release=1, ptr=1.
6. Assert rst during BUSY with grant=0100 -> next cycle grant=0, release=0, ptr=0. With req=4'b0101 afterward, grant=0001.
